// File: rtl/demux_rr_dispatch_if.sv
// Handshake and demux-side bus for demux_rr_dispatch.
// The master modport is the word source/consumer side; slave is the dispatcher.
interface demux_rr_dispatch_if #(
    parameter int N     = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ch_ready;
    logic [N-1:0]  y;
    logic [1:0]    sel;
    logic          out_valid;
    logic [CW-1:0] count;
    logic          stalled;

    modport master (
        output in_data, in_valid, ch_ready,
        input  in_ready, y, sel, out_valid, count, stalled
    );

    modport slave (
        input  in_data, in_valid, ch_ready,
        output in_ready, y, sel, out_valid, count, stalled
    );
endinterface

// File: rtl/demux_rr_dispatch.sv
// FIFO-buffered round-robin feeder for a 4-way demux (y/sel/out_valid).
// Optional macro DEMUX_RR_SKIP_EN: skip not-ready channels instead of stalling.
module demux_rr_dispatch #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux_rr_dispatch_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    logic [N-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic [1:0]    ptr_r;
    logic [N-1:0]  y_r;
    logic [1:0]    sel_r;
    logic          out_valid_r;
    logic          stalled_r;
    state_t        state_r;
    state_t        state_s;
    logic          push_s;
    logic          pop_s;
    logic [1:0]    ch_s;

`ifdef DEMUX_RR_SKIP_EN
    // First ready channel at or after p, wrapping; returns {found, channel}.
    function automatic logic [2:0] pick_channel(input logic [3:0] rdy, input logic [1:0] p);
        logic [3:0] rot;
        rot[0] = rdy[p];
        rot[1] = rdy[p + 2'd1];
        rot[2] = rdy[p + 2'd2];
        rot[3] = rdy[p + 2'd3];
        return rot[0] ? {1'b1, p} :
               rot[1] ? {1'b1, p + 2'd1} :
               rot[2] ? {1'b1, p + 2'd2} :
               rot[3] ? {1'b1, p + 2'd3} : {1'b0, p};
    endfunction
`endif

    // No write bypass: a full FIFO refuses input even when popping this edge.
    assign push_s        = bus.in_valid && (count_r != CW'(DEPTH));
    assign bus.in_ready  = (count_r != CW'(DEPTH));
    assign bus.y         = y_r;
    assign bus.sel       = sel_r;
    assign bus.out_valid = out_valid_r;
    assign bus.count     = count_r;
    assign bus.stalled   = stalled_r;

    // Dispatch decision: which channel the head word goes to on this edge.
    always_comb begin
        pop_s = 1'b0;
        ch_s  = ptr_r;
        if (count_r != '0) begin
`ifdef DEMUX_RR_SKIP_EN
            {pop_s, ch_s} = pick_channel(bus.ch_ready, ptr_r);
`else
            pop_s = bus.ch_ready[ptr_r];
            ch_s  = ptr_r;
`endif
        end else begin
            pop_s = 1'b0;
        end
    end

    // Occupancy after this edge.
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FSM next state; WAIT means the head was blocked on the last edge.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (push_s) begin
                    state_s = ST_SEND;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND, ST_WAIT: begin
                if (pop_s) begin
                    state_s = (count_next_s == '0) ? ST_IDLE : ST_SEND;
                end else if (count_r != '0) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = push_s ? ST_SEND : ST_IDLE;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= bus.in_data;
        end
    end

    // Pointers, occupancy, FSM state and registered demux outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            ptr_r       <= 2'd0;
            y_r         <= '0;
            sel_r       <= 2'd0;
            out_valid_r <= 1'b0;
            stalled_r   <= 1'b0;
            state_r     <= ST_IDLE;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                y_r         <= mem_r[rd_ptr_r];
                sel_r       <= ch_s;
                out_valid_r <= 1'b1;
                rd_ptr_r    <= rd_ptr_r + AW'(1);
                ptr_r       <= ch_s + 2'd1;
            end else begin
                out_valid_r <= 1'b0;
            end
            count_r   <= count_next_s;
            state_r   <= state_s;
            stalled_r <= (state_s == ST_WAIT);
        end
    end
endmodule
